// File: rtl/rom_burst_pkg.sv
// Shared types and ROM content generator for rom_burst_reader.
// Optional build macro: ROM_PARITY_EN adds a parity bit to every beat tag.
package rom_burst_pkg;

   // Widest word the content generator can produce.
   localparam int ROM_MAX_W = 64;

   localparam logic [7:0] BASE8 [8] = '{8'h33, 8'hCC, 8'h55, 8'hAA,
                                        8'hF0, 8'h0F, 8'h81, 8'h7E};

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // Sideband carried with each data word through the output buffer.
   typedef struct packed {
      logic last;
      logic err;
`ifdef ROM_PARITY_EN
      logic parity;
`endif
   } beat_tag_t;

   // Entry idx: base pattern repeated across the word, low bits XORed with idx/8.
   function automatic logic [ROM_MAX_W-1:0] rom_word(input int idx, input int width);
      logic [ROM_MAX_W-1:0] w;
      logic [7:0]           b;
      w = '0;
      b = BASE8[3'(idx % 8)];
      for (int k = 0; k < ROM_MAX_W; k++) begin
         if (k < width) w[6'(k)] = b[3'(k % 8)];
      end
      w = w ^ ROM_MAX_W'(idx / 8);
      return w;
   endfunction

endpackage

// File: rtl/rom_out_buf.sv
// Two-entry valid/ready FIFO holding response beats so a stalled consumer
// loses nothing. The head entry is a register, so outputs stay stable
// while the consumer stalls. count lets the producer gate new reads.
module rom_out_buf
   import rom_burst_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  beat_tag_t        push_tag,
   input  logic             pop_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output beat_tag_t        out_tag,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] data_q [2];
   beat_tag_t        tag_q  [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             wr;
   logic             pop;

   assign wr        = push && (count != 2'd2);
   assign pop       = out_valid && pop_ready;
   assign out_valid = (count != 2'd0);
   assign out_data  = data_q[rd_ptr];
   assign out_tag   = tag_q[rd_ptr];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            data_q[k] <= '0;
            tag_q[k]  <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr) begin
            data_q[wr_ptr] <= push_data;
            tag_q[wr_ptr]  <= push_tag;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(wr) - 2'(pop);
      end
   end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst reader over a generated, read-only lookup table.
// Optional build macro: ROM_PARITY_EN adds output resp_parity.
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   BURST | issuing one ROM read per cycle while the output buffer has room
//
// The ROM read is registered straight into the output buffer entry, so a read
// issued in cycle C is presented in C+1 and the buffer occupancy already
// accounts for every in-flight read.
module rom_burst_reader
   import rom_burst_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AW-1:0]    req_addr,
   input  logic [LEN_W-1:0] req_len,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_last,
   output logic             resp_err,
`ifdef ROM_PARITY_EN
   output logic             resp_parity,
`endif
   output logic             busy
);

   localparam int            ROM_ENTRIES = 1 << AW;
   localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);

   logic [WIDTH-1:0] rom_mem [ROM_ENTRIES];

   // Unused slots above DEPTH read as zero; they are only reachable in err_mode.
   for (genvar g = 0; g < ROM_ENTRIES; g++) begin : g_rom
      if (g < DEPTH) begin : g_used
         localparam logic [ROM_MAX_W-1:0] WORD = rom_word(g, WIDTH);
         assign rom_mem[g] = WORD[WIDTH-1:0];
      end else begin : g_pad
         assign rom_mem[g] = '0;
      end
   end

   logic addr_oob;
   if (DEPTH == ROM_ENTRIES) begin : g_full
      assign addr_oob = 1'b0;
   end else begin : g_part
      assign addr_oob = (req_addr >= AW'(DEPTH));
   end

   state_t           state;
   logic [AW-1:0]    addr;
   logic [LEN_W-1:0] beats_left;
   logic             err_mode;
   logic             issue;
   logic [1:0]       buf_count;
   logic [WIDTH-1:0] rom_rd;
   logic [WIDTH-1:0] push_data;
   beat_tag_t        push_tag;
   beat_tag_t        out_tag;

   assign issue  = (state == BURST) && (buf_count < 2'd2);
   assign rom_rd = rom_mem[addr];

   // Beat contents for the read issued this cycle.
   always_comb begin
      push_data     = err_mode ? '0 : rom_rd;
      push_tag      = '0;
      push_tag.last = (beats_left == '0);
      push_tag.err  = err_mode;
`ifdef ROM_PARITY_EN
      // Error beats carry deliberately wrong parity.
      push_tag.parity = err_mode ? 1'b1 : ^rom_rd;
`endif
   end

   // Request acceptance, address walk and burst length tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         addr       <= '0;
         beats_left <= '0;
         err_mode   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr       <= req_addr;
                  beats_left <= req_len;
                  err_mode   <= addr_oob;
                  state      <= BURST;
                  req_ready  <= 1'b0;
               end
            end
            BURST: begin
               if (issue) begin
                  if (beats_left == '0) begin
                     state     <= IDLE;
                     req_ready <= 1'b1;
                  end else begin
                     beats_left <= beats_left - LEN_W'(1);
                     if (!err_mode) addr <= (addr == LAST_ADDR) ? '0 : addr + AW'(1);
                  end
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   rom_out_buf #(
      .WIDTH(WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (issue),
      .push_data (push_data),
      .push_tag  (push_tag),
      .pop_ready (resp_ready),
      .out_valid (resp_valid),
      .out_data  (resp_data),
      .out_tag   (out_tag),
      .count     (buf_count)
   );

   assign resp_last = out_tag.last;
   assign resp_err  = out_tag.err;
`ifdef ROM_PARITY_EN
   assign resp_parity = out_tag.parity;
`endif
   assign busy = (state != IDLE) || (buf_count != 2'd0);

endmodule
